sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO. It is the general-purpose successor to the fixed 8x8 buffer, adding configurable data width and depth, programmable almost-full and almost-empty thresholds, and an optional first-word-fall-through (FWFT) read mode. It also accepts a write while full when a read is accepted in the same cycle, and records sticky overflow/underflow errors. It sits between producer and consumer blocks in the same clock domain, such as UART, command queues and stream adapters.

## Interface
- DATA_W, 8: word width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2. AW = log2(DEPTH).
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH; 0..DEPTH-1.
- FWFT, 0: 0 = registered standard read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESH.
- rd_en  in  1  read request (pop).
- data_out  out  DATA_W  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  AW+1  current number of stored words, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow/underflow.

## Operation
- rd_ok = rd_en & !empty.
- wr_ok = wr_en & (!full | rd_ok). A write while full is accepted when a read is accepted in the same cycle.
- On wr_ok: mem[wr_ptr] ← data_in; wr_ptr ← wr_ptr+1, wrapping mod DEPTH.
- On rd_ok: rd_ptr ← rd_ptr+1, wrapping mod DEPTH.
- count update:
  - +1 on wr_ok only.
  - −1 on rd_ok only.
  - unchanged on both or neither.
  - count never exceeds DEPTH and never goes below 0.
- empty, full, almost_full and almost_empty are combinational functions of the registered count.
- FWFT=0: data_out is a register. It loads mem[rd_ptr] on rd_ok and holds otherwise.
- FWFT=1: data_out = mem[rd_ptr] continuously. It is valid whenever !empty; rd_en acknowledges and pops the head word. When empty, its value is don't-care.
- Empty with wr_en & rd_en together: the write is accepted, the read is rejected, and underflow is set.
- Error flags:
  - overflow ← 1 when wr_en & !wr_ok.
  - underflow ← 1 when rd_en & empty.
  - clr_err clears both flags. If set and clear occur in the same cycle, set wins.
- Rejected operations change no pointer, count or memory contents.
- Memory contents are not reset.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - wr_ptr = rd_ptr = count = 0
  - empty = 1, full = 0
  - almost_empty = 1; almost_full = 1 only if AF_THRESH == 0 (not allowed, so 0)
  - overflow = underflow = 0
  - data_out = 0 in FWFT=0
- Reset mid-operation discards all stored words. Requests in the reset cycle are ignored.
- Write latency: a word written at edge N raises count and drops empty after edge N.
  - FWFT=1: the word appears on data_out during cycle N+1.
  - FWFT=0: the earliest read is rd_en in cycle N+1, and data appears after edge N+1.
- Flags and count update on the same edge as the operation that changes them. There is no extra pipeline stage.
- Throughput: one write and one read per cycle, sustained, including at full and empty boundaries as defined above.
- Pointer wrap: AW-bit pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by count only.

## Test plan
- **Reset:** With DATA_W=8, DEPTH=4 and FWFT=0, hold rst_n=0 for 2 cycles. Required: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, data_out=0x00.
- **Fill and drain:** Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: count 1,2,3,4; almost_full at count 2 (AF_THRESH=2); full at 4. A 5th write of 0x55 sets overflow, and count stays 4. Then read 4 times. Required: data_out 0x11, 0x22, 0x33, 0x44 in order; empty=1 after the last read. A further rd_en sets underflow while data_out holds 0x44.
- **Simultaneous at full:** When full with 0x11..0x44 stored, assert wr_en=1 (data_in 0xAA) and rd_en=1. Required: data_out=0x11, count stays 4, overflow stays 0. After draining, the read order is 0x22, 0x33, 0x44, 0xAA.
- **Simultaneous at empty:** When empty, assert wr_en (0x5A) and rd_en together. Required: count=1, underflow=1, and the next read returns 0x5A.
- **Wrap and FWFT:** With FWFT=1 and DEPTH=4, run 10 cycles of interleaved single writes and reads with incrementing data 0x00..0x09. Required: data_out equals the head word in the cycle after each write while !empty, pointers wrap with no data loss, and count stays in 0..1.
- **Error clear and mid-operation reset:** Assert clr_err in the same cycle as an overflowing write. Required: overflow=1, because set wins. The next cycle with clr_err alone clears it. A reset with count=3 returns count=0 and empty=1 on the next edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read, and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   CNT_AE   = (AW+1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_empty;
    logic              w_full;

    // Status flags derive from the registered count only, so full and empty
    // stay unambiguous even when the pointers are equal.
    always_comb begin
        w_empty = (r_count == CNT_ZERO);
        w_full  = (r_count == CNT_FULL);
        // A write while full is allowed only when a read frees a slot on the same edge.
        w_rd_ok = rd_en & ~w_empty;
        w_wr_ok = wr_en & (~w_full | w_rd_ok);
    end

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= CNT_AF);
    assign almost_empty = (r_count <= CNT_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end else begin
                r_underflow <= r_underflow;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented continuously; only meaningful while not empty.
            assign data_out = r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] r_data_out;

            // Registered read port: loads the head word on an accepted read.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data_out <= {DATA_W{1'b0}};
                end else if (w_rd_ok) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end else begin
                    r_data_out <= r_data_out;
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one
// stimulus stream and are checked against a queue-based model.
module tb_sync_fifo_param;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic       a_full, a_af, a_empty, a_ae, a_ov, a_un;
    logic [7:0] a_dout;
    logic [2:0] a_count;
    logic       b_full, b_af, b_empty, b_ae, b_ov, b_un;
    logic [7:0] b_dout;
    logic [2:0] b_count;

    sync_fifo_param #(.DATA_W(8), .DEPTH(D), .AF_THRESH(2), .AE_THRESH(1), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .full(a_full), .almost_full(a_af), .rd_en(rd_en), .data_out(a_dout),
        .empty(a_empty), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ov), .underflow(a_un), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(D), .AF_THRESH(2), .AE_THRESH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .full(b_full), .almost_full(b_af), .rd_en(rd_en), .data_out(b_dout),
        .empty(b_empty), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ov), .underflow(b_un), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus the standard-mode output register
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    bit         m_ov = 1'b0;
    bit         m_un = 1'b0;
    bit         chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rn);
        bit rok;
        bit wok;
        bit emp;
        wr_en = w; data_in = d; rd_en = r; clr_err = c; rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_dout = 8'h00;
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            emp = (q.size() == 0);
            rok = r && !emp;
            wok = w && (q.size() < D || rok);
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(d);
            if (w && !wok) m_ov = 1'b1; else if (c) m_ov = 1'b0;
            if (r && emp) m_un = 1'b1; else if (c) m_un = 1'b0;
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("count_std",  int'(a_count), q.size());
            check("count_fwft", int'(b_count), q.size());
            check("empty_std",  int'(a_empty), int'(q.size() == 0));
            check("full_std",   int'(a_full),  int'(q.size() == D));
            check("af_std",     int'(a_af),    int'(q.size() >= 2));
            check("ae_std",     int'(a_ae),    int'(q.size() <= 1));
            check("af_fwft",    int'(b_af),    int'(q.size() >= 2));
            check("ae_fwft",    int'(b_ae),    int'(q.size() <= 1));
            check("full_fwft",  int'(b_full),  int'(q.size() == D));
            check("empty_fwft", int'(b_empty), int'(q.size() == 0));
            check("ovf_std",    int'(a_ov),    int'(m_ov));
            check("udf_std",    int'(a_un),    int'(m_un));
            check("ovf_fwft",   int'(b_ov),    int'(m_ov));
            check("udf_fwft",   int'(b_un),    int'(m_un));
            check("dout_std",   int'(a_dout),  int'(m_dout));
            if (q.size() != 0) check("dout_fwft", int'(b_dout), int'(q[0]));
        end
    end

    logic [7:0] fillv [4];
    logic [7:0] drainv [4];

    initial begin
        fillv  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drainv = '{8'h22, 8'h33, 8'h44, 8'hAA};

        // Reset
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        check("rst_count", int'(a_count), 0);
        check("rst_empty", int'(a_empty), 1);
        check("rst_full",  int'(a_full), 0);
        check("rst_ae",    int'(a_ae), 1);
        check("rst_af",    int'(a_af), 0);
        check("rst_ov_un", int'({a_ov, a_un}), 0);
        check("rst_dout",  int'(a_dout), 8'h00);

        // Fill and drain
        for (int i = 0; i < 4; i++) begin
            step(1'b1, fillv[i], 1'b0, 1'b0, 1'b1);
            check("fill_count", int'(a_count), i + 1);
            check("fill_af", int'(a_af), int'(i >= 1));
            check("fill_full", int'(a_full), int'(i == 3));
        end
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        check("ovf_set", int'(a_ov), 1);
        check("ovf_count", int'(a_count), 4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            check("drain_dout", int'(a_dout), int'(fillv[i]));
        end
        check("drain_empty", int'(a_empty), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("udf_set", int'(a_un), 1);
        check("udf_hold_dout", int'(a_dout), 8'h44);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("clr_flags", int'({a_ov, a_un}), 0);

        // Simultaneous write and read at full
        for (int i = 0; i < 4; i++) step(1'b1, fillv[i], 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        check("simfull_dout", int'(a_dout), 8'h11);
        check("simfull_count", int'(a_count), 4);
        check("simfull_ov", int'(a_ov), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            check("simfull_drain", int'(a_dout), int'(drainv[i]));
        end

        // Simultaneous write and read at empty
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        check("simempty_count", int'(a_count), 1);
        check("simempty_un", int'(a_un), 1);
        check("simempty_fwft", int'(b_dout), 8'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("simempty_read", int'(a_dout), 8'h5A);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // FWFT wrap with interleaved writes and reads
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            check("fwft_head", int'(b_dout), i);
            check("fwft_count1", int'(b_count), 1);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            check("fwft_count0", int'(b_count), 0);
            check("wrap_std_dout", int'(a_dout), i);
        end

        // Error clear racing a set, then reset mid-operation
        for (int i = 0; i < 4; i++) step(1'b1, fillv[i], 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h66, 1'b0, 1'b1, 1'b1);
        check("setwins_ov", int'(a_ov), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("clr_ov", int'(a_ov), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("pre_rst_count", int'(a_count), 3);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("midrst_count", int'(a_count), 0);
        check("midrst_empty", int'(a_empty), 1);

        // Randomised traffic with phases biased toward full and toward empty
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = (i % 600 < 300) ? 75 : 25;
            step(bit'($urandom_range(0, 99) < wp), 8'($urandom),
                 bit'($urandom_range(0, 99) < 100 - wp),
                 bit'($urandom_range(0, 19) == 0),
                 bit'($urandom_range(0, 299) != 0));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
